// File: rtl/divisor_secuencial_if.sv
// Start/operand/result bundle for the sequential restoring divider.
interface divisor_secuencial_if #(
  parameter int unsigned SIZE = 4
);
  logic            inicio;
  logic [SIZE-1:0] dividendo;
  logic [SIZE-1:0] divisor;
  logic [SIZE-1:0] cociente;
  logic [SIZE-1:0] resto;
  logic            Ocupado;
  logic            Fin;
  logic            Error;

  modport master (
    output inicio, dividendo, divisor,
    input  cociente, resto, Ocupado, Fin, Error
  );

  modport slave (
    input  inicio, dividendo, divisor,
    output cociente, resto, Ocupado, Fin, Error
  );
endinterface

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider: one quotient bit per clock, SIZE+1 edges per result.
// Optional DIV_ZERO_DETECT_EN: divisor==0 short-circuits to DONE and raises Error.
module divisor_secuencial #(
  parameter int unsigned SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  divisor_secuencial_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state_q, state_d;

  // datapath registers
  logic [SIZE:0]   a_q, a_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] coc_q, coc_d;
  logic [SIZE-1:0] res_q, res_d;
  logic            fin_q, fin_d;
  logic            ocu_q, ocu_d;
`ifdef DIV_ZERO_DETECT_EN
  logic            err_q, err_d;
`endif

  logic [SIZE:0]   a_sh;
  logic [SIZE-1:0] q_sh;
  logic [SIZE:0]   t_diff;
  logic            start;
  logic            last_step;
  logic            zero_div;

  assign start     = (state_q != ITER) && bus.inicio;
  assign last_step = (cnt_q == CNT_W'(1));
`ifdef DIV_ZERO_DETECT_EN
  assign zero_div  = (m_q == '0);
`else
  assign zero_div  = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // control unit: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.inicio) state_d = ITER;
      ITER:       if (last_step || zero_div) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // one restoring step: shift {A,Q}, trial-subtract M, sign bit decides
  always_comb begin
    a_sh   = {a_q[SIZE-1:0], q_q[SIZE-1]};
    q_sh   = {q_q[SIZE-2:0], 1'b0};
    t_diff = a_sh - {1'b0, m_q};
  end

  // datapath / output register next values
  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    coc_d = coc_q;
    res_d = res_q;
    fin_d = fin_q;
    ocu_d = ocu_q;
`ifdef DIV_ZERO_DETECT_EN
    err_d = err_q;
`endif
    if (start) begin
      a_d   = '0;
      q_d   = bus.dividendo;
      m_d   = bus.divisor;
      cnt_d = CNT_W'(SIZE);
      fin_d = 1'b0;
      ocu_d = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
      err_d = 1'b0;
`endif
    end else if (state_q == ITER) begin
      if (zero_div) begin
        cnt_d = '0;
        coc_d = '1;
        res_d = q_q;
        fin_d = 1'b1;
        ocu_d = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        err_d = 1'b1;
`endif
      end else begin
        if (t_diff[SIZE]) begin
          a_d = a_sh;
          q_d = q_sh;
        end else begin
          a_d = t_diff;
          q_d = q_sh | SIZE'(1);
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (last_step) begin
          coc_d = q_d;
          res_d = a_d[SIZE-1:0];
          fin_d = 1'b1;
          ocu_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      coc_q <= '0;
      res_q <= '0;
      fin_q <= 1'b0;
      ocu_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      err_q <= 1'b0;
`endif
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      coc_q <= coc_d;
      res_q <= res_d;
      fin_q <= fin_d;
      ocu_q <= ocu_d;
`ifdef DIV_ZERO_DETECT_EN
      err_q <= err_d;
`endif
    end
  end

  assign bus.cociente = coc_q;
  assign bus.resto    = res_q;
  assign bus.Fin      = fin_q;
  assign bus.Ocupado  = ocu_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.Error    = err_q;
`else
  assign bus.Error    = 1'b0;
`endif
endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial (SIZE=4) plus a SIZE=8 random identity sweep.
module tb_divisor_secuencial;
  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  divisor_secuencial_if #(.SIZE(4)) bus4 ();
  divisor_secuencial_if #(.SIZE(8)) bus8 ();

  divisor_secuencial #(.SIZE(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  divisor_secuencial #(.SIZE(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Apply a start edge, then count edges (start edge = 1) until Fin; Ocupado cycles counted alongside.
  task automatic run4(input logic [3:0] dd, input logic [3:0] dv,
                      output int lat, output int ocu);
    @(negedge clk);
    bus4.inicio = 1'b1; bus4.dividendo = dd; bus4.divisor = dv;
    @(posedge clk); #1;
    bus4.inicio = 1'b0;
    lat = 1;
    ocu = bus4.Ocupado ? 1 : 0;
    while (!bus4.Fin && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus4.Ocupado) ocu++;
    end
  endtask

  task automatic op4(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                     input int exp_q, input int exp_r, input int exp_e, input int exp_lat);
    int lat, ocu;
    run4(dd, dv, lat, ocu);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ocu"}, 32'(ocu), 32'(exp_lat - 1));
    chk({tag, "_q"},   32'(bus4.cociente), 32'(exp_q));
    chk({tag, "_r"},   32'(bus4.resto), 32'(exp_r));
    chk({tag, "_err"}, 32'(bus4.Error), 32'(exp_e));
  endtask

  initial begin
    int lat, ocu;
    logic [7:0] dd8, dv8;
    bus4.inicio = 1'b0; bus4.dividendo = '0; bus4.divisor = '0;
    bus8.inicio = 1'b0; bus8.dividendo = '0; bus8.divisor = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q",   32'(bus4.cociente), 0);
    chk("rst_r",   32'(bus4.resto), 0);
    chk("rst_fin", 32'(bus4.Fin), 0);
    chk("rst_ocu", 32'(bus4.Ocupado), 0);
    chk("rst_err", 32'(bus4.Error), 0);
    @(negedge clk); reset = 1'b0;

    op4("d13_3", 4'd13, 4'd3, 4, 1, 0, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_fin", 32'(bus4.Fin), 1);
    chk("hold_q",   32'(bus4.cociente), 4);
    chk("hold_r",   32'(bus4.resto), 1);

    // back-to-back starts, each issued from DONE
    op4("d15_1", 4'd15, 4'd1, 15, 0, 0, 5);
    op4("d7_9",  4'd7,  4'd9, 0, 7, 0, 5);
    op4("d0_5",  4'd0,  4'd5, 0, 0, 0, 5);
`ifdef DIV_ZERO_DETECT_EN
    op4("d11_0", 4'd11, 4'd0, 15, 11, 1, 2);
    op4("clrerr", 4'd6, 4'd3, 2, 0, 0, 5);
`else
    op4("d11_0", 4'd11, 4'd0, 15, 11, 0, 5);
`endif

    // inicio pulsed mid-ITER with other operands is ignored
    @(negedge clk);
    bus4.inicio = 1'b1; bus4.dividendo = 4'd13; bus4.divisor = 4'd3;
    @(negedge clk);
    bus4.inicio = 1'b0;
    @(negedge clk);
    bus4.inicio = 1'b1; bus4.dividendo = 4'd9; bus4.divisor = 4'd2;
    @(negedge clk);
    bus4.inicio = 1'b0;
    lat = 3;
    while (!bus4.Fin && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", 32'(lat), 5);
    chk("ign_q",   32'(bus4.cociente), 4);
    chk("ign_r",   32'(bus4.resto), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("ign_ocu", 32'(bus4.Ocupado), 0);
    chk("ign_fin", 32'(bus4.Fin), 1);

    // reset sampled on the 3rd ITER edge
    @(negedge clk);
    bus4.inicio = 1'b1; bus4.dividendo = 4'd13; bus4.divisor = 4'd3;
    @(negedge clk);
    bus4.inicio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_q",   32'(bus4.cociente), 0);
    chk("mid_r",   32'(bus4.resto), 0);
    chk("mid_fin", 32'(bus4.Fin), 0);
    chk("mid_ocu", 32'(bus4.Ocupado), 0);
    chk("mid_err", 32'(bus4.Error), 0);
    // reset wins over a simultaneous start
    @(negedge clk);
    bus4.inicio = 1'b1; bus4.dividendo = 4'd9; bus4.divisor = 4'd2;
    @(posedge clk); #1;
    chk("prio_ocu", 32'(bus4.Ocupado), 0);
    @(negedge clk);
    bus4.inicio = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ocu", 32'(bus4.Ocupado), 0);
    op4("d6_4", 4'd6, 4'd4, 1, 2, 0, 5);

    // SIZE=8 random sweep against the division identity
    for (int k = 0; k < 40; k++) begin
      dd8 = 8'($urandom_range(0, 255));
      dv8 = 8'($urandom_range(1, 255));
      @(negedge clk);
      bus8.inicio = 1'b1; bus8.dividendo = dd8; bus8.divisor = dv8;
      @(posedge clk); #1;
      bus8.inicio = 1'b0;
      lat = 1;
      while (!bus8.Fin && lat < 30) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("s8_lat", 32'(lat), 9);
      chk("s8_q",   32'(bus8.cociente), 32'(dd8 / dv8));
      chk("s8_r",   32'(bus8.resto), 32'(dd8 % dv8));
      chk("s8_id",  32'(bus8.cociente) * 32'(dv8) + 32'(bus8.resto), 32'(dd8));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
